// File: rtl/gpio_ctrl_pkg.sv
// Shared types and helpers for the gpio port controller.
// Latency: n/a (types and a constant-foldable function only).
// Backpressure: n/a.
//
// Contents:
//   wr_state_e  - write-side FSM states (IDLE, HOLD)
//   hold_cnt_t  - hold-period counter, wide enough for HOLD_CYCLES up to 255
//   slice_lo()  - low bit index of requester idx inside a packed per-requester bus

package gpio_ctrl_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } wr_state_e;

   typedef logic [7:0] hold_cnt_t;

   // Requester idx owns bits [idx*width +: width] of req_data / req_mask.
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Round-robin request selector for the gpio write port.
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: none internally; caller decides whether the grant is honoured.
//
// Ports:
//   req_i      - per-requester request vector
//   rr_ptr_i   - index with highest priority this cycle
//   gnt_o      - one-hot grant (all zero when no request)
//   gnt_idx_o  - binary index of the granted requester
//   gnt_vld_o  - at least one request present

module gpio_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_vld_o
);

   logic found;

   // Two ordered passes instead of a modulo index: the first pass only
   // considers requesters at or above the pointer, the second picks up the
   // wrapped-around ones below it. Loop indices stay constant per iteration.
   always_comb begin
      found     = 1'b0;
      gnt_o     = '0;
      gnt_idx_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_i[i] && (i >= int'(rr_ptr_i))) begin
            found     = 1'b1;
            gnt_o[i]  = 1'b1;
            gnt_idx_o = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_i[i]) begin
            found     = 1'b1;
            gnt_o[i]  = 1'b1;
            gnt_idx_o = IDX_W'(i);
         end
      end
      gnt_vld_o = found;
   end

endmodule

// File: rtl/gpio_port_ctrl.sv
// Owns a gpio bus: arbitrated masked writes to write_port, change events from read_port.
// Latency: accepted write visible on write_port after 1 edge; read_port change -> evt_valid after 3 edges.
// Backpressure: req_ready drops for HOLD_CYCLES after each accept; unaccepted events coalesce in one slot.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid/ready   - per-requester write handshake (ready one-hot or zero)
//   req_data/req_mask - packed per-requester data and bit-enables
//   write_port        - registered gpio drive
//   read_port         - asynchronous gpio inputs
//   evt_valid/ready   - change-event handshake
//   evt_data          - latest synchronized read_port value
//   evt_changed       - bits toggled since the last accepted event
//   evt_overflow      - more than one change folded into the pending event
//   busy              - write side is in its hold period

module gpio_port_ctrl
   import gpio_ctrl_pkg::*;
#(
   parameter int                          READ_PORT_WIDTH  = 4,
   parameter int                          WRITE_PORT_WIDTH = 4,
   parameter int                          NUM_REQ          = 2,
   parameter int                          HOLD_CYCLES      = 2,
   parameter logic [WRITE_PORT_WIDTH-1:0] WRITE_RESET_VAL  = '0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ*WRITE_PORT_WIDTH-1:0] req_data,
   input  logic [NUM_REQ*WRITE_PORT_WIDTH-1:0] req_mask,
   output logic [WRITE_PORT_WIDTH-1:0]         write_port,
   input  logic [READ_PORT_WIDTH-1:0]          read_port,
   output logic                                evt_valid,
   input  logic                                evt_ready,
   output logic [READ_PORT_WIDTH-1:0]          evt_data,
   output logic [READ_PORT_WIDTH-1:0]          evt_changed,
   output logic                                evt_overflow,
   output logic                                busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Counter value loaded on accept; the HOLD branch is never entered when
   // HOLD_CYCLES is zero, so the load value is irrelevant in that case.
   localparam hold_cnt_t HOLD_LOAD = (HOLD_CYCLES > 0) ? hold_cnt_t'(HOLD_CYCLES - 1) : '0;

   // ------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------
   wr_state_e                   state_q;
   hold_cnt_t                   hold_cnt_q;
   logic                        busy_q;
   logic [IDX_W-1:0]            rr_ptr_q;
   logic [IDX_W-1:0]            rr_ptr_d;
   logic [WRITE_PORT_WIDTH-1:0] write_port_q;
   logic [WRITE_PORT_WIDTH-1:0] write_port_d;

   logic [NUM_REQ-1:0]          gnt;
   logic [IDX_W-1:0]            gnt_idx;
   logic                        gnt_vld;
   logic                        accept;

   logic [WRITE_PORT_WIDTH-1:0] data_slice [NUM_REQ];
   logic [WRITE_PORT_WIDTH-1:0] mask_slice [NUM_REQ];
   logic [WRITE_PORT_WIDTH-1:0] sel_data;
   logic [WRITE_PORT_WIDTH-1:0] sel_mask;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign data_slice[g] = req_data[slice_lo(g, WRITE_PORT_WIDTH) +: WRITE_PORT_WIDTH];
      assign mask_slice[g] = req_mask[slice_lo(g, WRITE_PORT_WIDTH) +: WRITE_PORT_WIDTH];
   end

   gpio_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_i     (req_valid),
      .rr_ptr_i  (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   // Ready is gated by rst so it drops the instant reset is asserted,
   // not only after the state register has been cleared.
   assign req_ready = (state_q == IDLE && !rst && gnt_vld) ? gnt : '0;
   assign accept    = |(req_valid & req_ready);

   // Grant is one-hot, so OR-ing the selected slices is a clean mux.
   always_comb begin
      sel_data = '0;
      sel_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_data = sel_data | data_slice[i];
            sel_mask = sel_mask | mask_slice[i];
         end
      end
   end

   assign write_port_d = (write_port_q & ~sel_mask) | (sel_data & sel_mask);
   assign rr_ptr_d     = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

   // Write FSM. A zero mask is still a full accept: it advances the pointer
   // and starts a hold period even though write_port keeps its value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_cnt_q   <= '0;
         busy_q       <= 1'b0;
         rr_ptr_q     <= '0;
         write_port_q <= WRITE_RESET_VAL;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  write_port_q <= write_port_d;
                  rr_ptr_q     <= rr_ptr_d;
                  if (HOLD_CYCLES > 0) begin
                     state_q    <= HOLD;
                     hold_cnt_q <= HOLD_LOAD;
                     busy_q     <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (hold_cnt_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  hold_cnt_q <= hold_cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign write_port = write_port_q;
   assign busy       = busy_q;

   // ------------------------------------------------------------------
   // Read side
   // ------------------------------------------------------------------
   logic [READ_PORT_WIDTH-1:0] sync1_q;
   logic [READ_PORT_WIDTH-1:0] sync2_q;
   logic [READ_PORT_WIDTH-1:0] prev_q;
   logic [READ_PORT_WIDTH-1:0] diff;

   logic                       evt_valid_q;
   logic [READ_PORT_WIDTH-1:0] evt_data_q;
   logic [READ_PORT_WIDTH-1:0] evt_changed_q;
   logic                       evt_overflow_q;

   assign diff = sync2_q ^ prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= read_port;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Single-entry event slot. A change arriving while the slot is full and
   // not being drained is folded in (changed bits OR-ed, overflow flagged);
   // a change arriving in the same cycle as the drain starts a fresh event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid_q    <= 1'b0;
         evt_data_q     <= '0;
         evt_changed_q  <= '0;
         evt_overflow_q <= 1'b0;
      end else if (diff != '0) begin
         evt_valid_q <= 1'b1;
         evt_data_q  <= sync2_q;
         if (!evt_valid_q || evt_ready) begin
            evt_changed_q  <= diff;
            evt_overflow_q <= 1'b0;
         end else begin
            evt_changed_q  <= evt_changed_q | diff;
            evt_overflow_q <= 1'b1;
         end
      end else if (evt_valid_q && evt_ready) begin
         evt_valid_q    <= 1'b0;
         evt_changed_q  <= '0;
         evt_overflow_q <= 1'b0;
      end
   end

   assign evt_valid    = evt_valid_q;
   assign evt_data     = evt_data_q;
   assign evt_changed  = evt_changed_q;
   assign evt_overflow = evt_overflow_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Bench for gpio_port_ctrl: two instances sharing all inputs,
// index 0 built with HOLD_CYCLES=2 and index 1 with HOLD_CYCLES=0.
// Directed sequences and a vector table first, then random traffic against a reference model.

module tb_gpio_port_ctrl;

   logic       clk;
   logic       rst;
   logic [1:0] req_valid;
   logic [7:0] req_data;
   logic [7:0] req_mask;
   logic [3:0] read_port;
   logic       evt_ready;

   logic [1:0] rdy_o  [2];
   logic [3:0] wp_o   [2];
   logic       busy_o [2];
   logic       ev_v   [2];
   logic [3:0] ev_d   [2];
   logic [3:0] ev_c   [2];
   logic       ev_o   [2];

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   gpio_port_ctrl #(
      .READ_PORT_WIDTH(4), .WRITE_PORT_WIDTH(4), .NUM_REQ(2),
      .HOLD_CYCLES(2), .WRITE_RESET_VAL(4'h0)
   ) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(rdy_o[0]),
      .req_data(req_data), .req_mask(req_mask),
      .write_port(wp_o[0]), .read_port(read_port),
      .evt_valid(ev_v[0]), .evt_ready(evt_ready),
      .evt_data(ev_d[0]), .evt_changed(ev_c[0]),
      .evt_overflow(ev_o[0]), .busy(busy_o[0])
   );

   gpio_port_ctrl #(
      .READ_PORT_WIDTH(4), .WRITE_PORT_WIDTH(4), .NUM_REQ(2),
      .HOLD_CYCLES(0), .WRITE_RESET_VAL(4'h0)
   ) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(rdy_o[1]),
      .req_data(req_data), .req_mask(req_mask),
      .write_port(wp_o[1]), .read_port(read_port),
      .evt_valid(ev_v[1]), .evt_ready(evt_ready),
      .evt_data(ev_d[1]), .evt_changed(ev_c[1]),
      .evt_overflow(ev_o[1]), .busy(busy_o[1])
   );

   typedef struct {
      logic [1:0] vld;
      logic [7:0] dat;
      logic [7:0] msk;
      logic [1:0] exp_rdy;
      logic [3:0] exp_wp;
   } vec_t;

   vec_t vecs[7];

   // Reference model state
   int         m_ptr  [2];
   int         m_next [2];
   logic [3:0] m_wp   [2];
   int         m_hold [2];
   logic [3:0] m_hist [3];   // read_port as sampled at the last three edges
   logic       m_ev;
   logic [3:0] m_ed;
   logic [3:0] m_ec;
   logic       m_eo;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_mask  = '0;
      read_port = '0;
      evt_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ptr[k]  = 0;
         m_next[k] = 0;
         m_wp[k]   = 4'h0;
      end
      m_hold[0] = 2;
      m_hold[1] = 0;
      for (int j = 0; j < 3; j++) m_hist[j] = 4'h0;
      m_ev = 1'b0;
      m_ed = 4'h0;
      m_ec = 4'h0;
      m_eo = 1'b0;
   endtask

   // Compare both instances for cycle c, then advance the model past the next edge.
   task automatic model_cycle(input int c);
      int         g;
      int         idx;
      logic [1:0] exp_rdy;
      logic [3:0] d;
      logic [3:0] m;
      logic [3:0] chg;
      for (int k = 0; k < 2; k++) begin
         g = -1;
         if (c >= m_next[k]) begin
            for (int s = 0; s < 2; s++) begin
               idx = (m_ptr[k] + s) % 2;
               if (g < 0 && req_valid[idx]) g = idx;
            end
         end
         exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
         check($sformatf("rnd%0d c%0d ready", k, c), rdy_o[k], exp_rdy);
         check($sformatf("rnd%0d c%0d write_port", k, c), wp_o[k], m_wp[k]);
         check($sformatf("rnd%0d c%0d busy", k, c), busy_o[k], (c < m_next[k]));
         check($sformatf("rnd%0d c%0d evt_valid", k, c), ev_v[k], m_ev);
         check($sformatf("rnd%0d c%0d evt_data", k, c), ev_d[k], m_ed);
         check($sformatf("rnd%0d c%0d evt_changed", k, c), ev_c[k], m_ec);
         check($sformatf("rnd%0d c%0d evt_overflow", k, c), ev_o[k], m_eo);
         if (g >= 0) begin
            d         = 4'(req_data >> (4 * g));
            m         = 4'(req_mask >> (4 * g));
            m_wp[k]   = (m_wp[k] & ~m) | (d & m);
            m_ptr[k]  = (g + 1) % 2;
            m_next[k] = c + m_hold[k] + 1;
         end
      end
      // Change seen this cycle: newest synchronized value vs the one before it.
      chg = m_hist[1] ^ m_hist[2];
      if (chg != 4'h0) begin
         if (!m_ev || evt_ready) begin
            m_ec = chg;
            m_eo = 1'b0;
         end else begin
            m_ec = m_ec | chg;
            m_eo = 1'b1;
         end
         m_ev = 1'b1;
         m_ed = m_hist[1];
      end else if (m_ev && evt_ready) begin
         m_ev = 1'b0;
         m_ec = 4'h0;
         m_eo = 1'b0;
      end
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = read_port;
   endtask

   initial begin
      // HOLD_CYCLES=0 vector table (instance 1): requester 1 for four cycles, then idle, then both.
      vecs[0] = '{2'b10, 8'hA0, 8'hF0, 2'b10, 4'hA};
      vecs[1] = '{2'b10, 8'h50, 8'h30, 2'b10, 4'h9};
      vecs[2] = '{2'b10, 8'hF0, 8'h00, 2'b10, 4'h9};
      vecs[3] = '{2'b10, 8'h60, 8'hC0, 2'b10, 4'h5};
      vecs[4] = '{2'b00, 8'h00, 8'h00, 2'b00, 4'h5};
      vecs[5] = '{2'b11, 8'h0F, 8'hFF, 2'b01, 4'hF};
      vecs[6] = '{2'b11, 8'h0F, 8'hFF, 2'b10, 4'h0};

      // ---- reset values while in reset, with requests pending ----
      rst       = 1'b1;
      req_valid = 2'b11;
      req_data  = 8'hFF;
      req_mask  = 8'hFF;
      read_port = 4'h0;
      evt_ready = 1'b0;
      #2;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset%0d write_port", k), wp_o[k], 4'h0);
         check($sformatf("reset%0d req_ready", k), rdy_o[k], 2'b00);
         check($sformatf("reset%0d busy", k), busy_o[k], 1'b0);
         check($sformatf("reset%0d evt_valid", k), ev_v[k], 1'b0);
         check($sformatf("reset%0d evt_data", k), ev_d[k], 4'h0);
         check($sformatf("reset%0d evt_changed", k), ev_c[k], 4'h0);
         check($sformatf("reset%0d evt_overflow", k), ev_o[k], 1'b0);
      end

      // ---- masked write with hold period (instance 0) ----
      do_reset();
      req_valid = 2'b01;
      req_data  = 8'h0F;
      req_mask  = 8'h05;
      #1;
      check("mw ready before accept", rdy_o[0], 2'b01);
      check("mw busy before accept", busy_o[0], 1'b0);
      tick();
      check("mw write_port", wp_o[0], 4'h5);
      check("mw busy hold1", busy_o[0], 1'b1);
      check("mw ready hold1", rdy_o[0], 2'b00);
      tick();
      check("mw busy hold2", busy_o[0], 1'b1);
      check("mw ready hold2", rdy_o[0], 2'b00);
      check("mw write_port held", wp_o[0], 4'h5);
      tick();
      check("mw busy after hold", busy_o[0], 1'b0);
      check("mw ready after hold", rdy_o[0], 2'b01);
      req_valid = 2'b00;

      // ---- round robin with both requesting constantly ----
      do_reset();
      req_valid = 2'b11;
      req_data  = 8'h21;
      req_mask  = 8'hFF;
      for (int c = 0; c < 12; c++) begin
         #1;
         check($sformatf("rr0 c%0d ready", c), rdy_o[0],
               (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10));
         check($sformatf("rr1 c%0d ready", c), rdy_o[1], (c % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         check($sformatf("rr0 c%0d write_port", c), wp_o[0], (((c / 3) % 2) == 0) ? 4'h1 : 4'h2);
         check($sformatf("rr1 c%0d write_port", c), wp_o[1], (c % 2 == 0) ? 4'h1 : 4'h2);
      end

      // ---- HOLD_CYCLES=0 vector table ----
      do_reset();
      for (int v = 0; v < 7; v++) begin
         req_valid = vecs[v].vld;
         req_data  = vecs[v].dat;
         req_mask  = vecs[v].msk;
         #1;
         check($sformatf("vec%0d ready", v), rdy_o[1], vecs[v].exp_rdy);
         tick();
         check($sformatf("vec%0d write_port", v), wp_o[1], vecs[v].exp_wp);
      end

      // ---- read change: 0 -> 3, visible at the third edge ----
      do_reset();
      read_port = 4'h3;
      tick();
      check("rd edge1 evt_valid", ev_v[0], 1'b0);
      tick();
      check("rd edge2 evt_valid", ev_v[0], 1'b0);
      tick();
      check("rd edge3 evt_valid", ev_v[0], 1'b1);
      check("rd evt_data", ev_d[0], 4'h3);
      check("rd evt_changed", ev_c[0], 4'h3);
      check("rd evt_overflow", ev_o[0], 1'b0);
      tick();
      check("rd held evt_valid", ev_v[0], 1'b1);
      evt_ready = 1'b1;
      tick();
      check("rd drained evt_valid", ev_v[0], 1'b0);
      check("rd drained evt_changed", ev_c[0], 4'h0);
      evt_ready = 1'b0;

      // ---- coalescing and accept-with-new-change ----
      do_reset();
      tick();
      read_port = 4'h1;
      tick();
      read_port = 4'h9;
      tick();
      tick();
      check("co first evt_data", ev_d[0], 4'h1);
      check("co first evt_overflow", ev_o[0], 1'b0);
      tick();
      check("co evt_data", ev_d[0], 4'h9);
      check("co evt_changed", ev_c[0], 4'h9);
      check("co evt_overflow", ev_o[0], 1'b1);
      read_port = 4'h8;
      tick();
      check("co stable evt_data", ev_d[0], 4'h9);
      check("co stable evt_changed", ev_c[0], 4'h9);
      tick();
      evt_ready = 1'b1;
      tick();
      check("co reload evt_valid", ev_v[0], 1'b1);
      check("co reload evt_changed", ev_c[0], 4'h1);
      check("co reload evt_overflow", ev_o[0], 1'b0);
      check("co reload evt_data", ev_d[0], 4'h8);
      tick();
      check("co drain evt_valid", ev_v[0], 1'b0);
      evt_ready = 1'b0;

      // ---- asynchronous reset in mid-cycle ----
      do_reset();
      req_valid = 2'b01;
      req_data  = 8'h0F;
      req_mask  = 8'h0F;
      read_port = 4'h5;
      repeat (4) tick();
      check("ar pre write_port", wp_o[0], 4'hF);
      check("ar pre evt_valid", ev_v[0], 1'b1);
      #2;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("ar%0d write_port", k), wp_o[k], 4'h0);
         check($sformatf("ar%0d evt_valid", k), ev_v[k], 1'b0);
         check($sformatf("ar%0d req_ready", k), rdy_o[k], 2'b00);
         check($sformatf("ar%0d busy", k), busy_o[k], 1'b0);
      end
      tick();
      rst       = 1'b0;
      req_valid = 2'b00;
      tick();
      tick();
      check("ar post edge2 evt_valid", ev_v[0], 1'b0);
      tick();
      check("ar post evt_valid", ev_v[0], 1'b1);
      check("ar post evt_data", ev_d[0], 4'h5);
      check("ar post evt_changed", ev_c[0], 4'h5);

      // ---- random traffic against the model ----
      do_reset();
      model_reset();
      for (int c = 0; c < 600; c++) begin
         req_valid = 2'($urandom);
         req_data  = 8'($urandom);
         req_mask  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) read_port = 4'($urandom);
         evt_ready = 1'($urandom);
         #2;
         model_cycle(c);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
